// File: rtl/bus_arb_pkg.sv
// Shared constants, state encoding and helpers for the bus arbiter slice.
package bus_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    // Reset value of the last-owner register: makes requester 0 the first favourite.
    localparam logic [ID_W-1:0] LAST_RESET = ID_W'(3);

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first set request after the last owner,
// wrapping around so the last owner itself is checked last.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] idx;

    // Search last+1 .. last+NUM_REQ (mod NUM_REQ), taking the first hit.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = last + ID_W'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the 4:1 data-bus mux: one-hot grant, registered mux
// select, one-cycle turnaround gap and timeout preemption under contention.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s1,
    output logic               s0,
    output logic               valid,
    output logic               preempt
);

    localparam int unsigned      CNT_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    arb_state_t         state, state_nxt;
    logic [ID_W-1:0]    last, last_nxt;
    logic [CNT_W-1:0]   hold_cnt, cnt_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic [ID_W-1:0]    sel_q, sel_nxt;
    logic               valid_q, valid_nxt;
    logic               preempt_q, preempt_nxt;

    logic               found;
    logic [ID_W-1:0]    winner;
    logic               others_waiting;

    rr_pick u_rr_pick (
        .req    (req),
        .last   (last),
        .found  (found),
        .winner (winner)
    );

    assign others_waiting = |(req & ~id_to_onehot(last));

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        cnt_nxt     = hold_cnt;
        gnt_nxt     = gnt_q;
        sel_nxt     = sel_q;
        valid_nxt   = valid_q;
        preempt_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_nxt   = '0;
                valid_nxt = 1'b0;
                if (found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = id_to_onehot(winner);
                    sel_nxt   = winner;
                    last_nxt  = winner;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (!req[last]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end else if (hold_cnt == CNT_MAX && others_waiting) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    valid_nxt   = 1'b0;
                    preempt_nxt = 1'b1;
                end else if (hold_cnt != CNT_MAX) begin
                    cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= LAST_RESET;
            hold_cnt  <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            hold_cnt  <= cnt_nxt;
            gnt_q     <= gnt_nxt;
            sel_q     <= sel_nxt;
            valid_q   <= valid_nxt;
            preempt_q <= preempt_nxt;
        end
    end

    assign gnt      = gnt_q;
    assign {s1, s0} = sel_q;
    assign valid    = valid_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with HOLD_MAX = 8.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1, s0, valid, preempt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bus_arbiter #(.HOLD_MAX(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .s1      (s1),
        .s0      (s0),
        .valid   (valid),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [3:0] exp_gnt,
                             input logic [1:0] exp_sel, input logic exp_pre);
        check({tag, ".gnt"},     32'(gnt),      32'(exp_gnt));
        check({tag, ".sel"},     32'({s1, s0}), 32'(exp_sel));
        check({tag, ".valid"},   32'(valid),    32'(|exp_gnt));
        check({tag, ".preempt"}, 32'(preempt),  32'(exp_pre));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;

        // Reset, then idle with no requests
        apply_reset();
        check_bus("rst", 4'b0000, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_bus($sformatf("idle%0d", i), 4'b0000, 2'b00, 1'b0);
        end

        // All four requesting: 0,1,2,3,0 with 8-cycle tenures and a preempt gap
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] own;
            own = 2'(k % 4);
            for (int c = 1; c <= 8; c++) begin
                step();
                check_bus($sformatf("rr%0d_c%0d", k, c), 4'b0001 << own, own, 1'b0);
            end
            step();
            check_bus($sformatf("rr%0d_gap", k), 4'b0000, own, 1'b1);
        end

        // Voluntary release by requester 2
        apply_reset();
        req = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            step();
            check_bus($sformatf("rel_c%0d", c), 4'b0100, 2'b10, 1'b0);
        end
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            check_bus($sformatf("rel_idle%0d", c), 4'b0000, 2'b10, 1'b0);
        end

        // Sole requester keeps the bus with no preemption
        apply_reset();
        req = 4'b0010;
        for (int c = 1; c <= 20; c++) begin
            step();
            check_bus($sformatf("sole_c%0d", c), 4'b0010, 2'b01, 1'b0);
        end
        req = 4'b0000;
        step();
        check_bus("sole_rel", 4'b0000, 2'b01, 1'b0);

        // Late contender: owner 0 revoked after 8 grant cycles, then requester 3
        apply_reset();
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            check_bus($sformatf("late_c%0d", c), 4'b0001, 2'b00, 1'b0);
            if (c == 5) req = 4'b1001;
        end
        step();
        check_bus("late_gap", 4'b0000, 2'b00, 1'b1);
        step();
        check_bus("late_new", 4'b1000, 2'b11, 1'b0);
        step();
        check_bus("late_new2", 4'b1000, 2'b11, 1'b0);

        // Reset in the middle of a grant
        apply_reset();
        req = 4'b0010;
        step();
        check_bus("mid_g1", 4'b0010, 2'b01, 1'b0);
        step();
        check_bus("mid_g2", 4'b0010, 2'b01, 1'b0);
        reset = 1'b1;
        step();
        check_bus("mid_rst", 4'b0000, 2'b00, 1'b0);
        reset = 1'b0;
        req   = 4'b1111;
        step();
        check_bus("mid_first", 4'b0001, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
